// File: rtl/mobo_mem_responder_pkg.sv
// Shared mobo bus encodings: CPU request codes and responder status codes.
package mobo_mem_responder_pkg;

    localparam int unsigned CTRL_NONE  = 0;
    localparam int unsigned CTRL_WRITE = 1;
    localparam int unsigned CTRL_READ  = 2;

    localparam int unsigned STAT_IDLE = 0;
    localparam int unsigned STAT_BUSY = 1;
    localparam int unsigned STAT_DONE = 2;
    localparam int unsigned STAT_ERR  = 3;

    localparam int unsigned STAT_W = 2;

endpackage

// File: rtl/mobo_mem_responder_mem_array.sv
// Word memory for the mobo responder: synchronous write, registered read.
// Storage is not reset; only the read-data register clears on reset.
module mobo_mem_array #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    // Write port; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; holds until the next read completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mobo_mem_responder.sv
// Mobo-side memory responder for the CTRL_*/STAT_* CPU handshake.
// Optional feature: MOBO_RESP_RANGE_CHECK_EN -- when defined, addresses at or
// above 2**DEPTH_LOG2 end in STAT_ERR; otherwise addresses wrap modulo depth.
module mobo_mem_responder
    import mobo_mem_responder_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] mobo_ctrl,
    input  logic [WORD_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] mobodat_out,
    output logic [WORD_WIDTH-1:0] mobo_stat,
    output logic [WORD_WIDTH-1:0] mobodat_in
);

    // State codes equal the status codes, so mobo_stat is the state register.
    localparam logic [1:0] S_IDLE = 2'(STAT_IDLE);
    localparam logic [1:0] S_BUSY = 2'(STAT_BUSY);
    localparam logic [1:0] S_DONE = 2'(STAT_DONE);
    localparam logic [1:0] S_ERR  = 2'(STAT_ERR);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef MOBO_RESP_RANGE_CHECK_EN
    localparam int unsigned ADDR_Q_W = WORD_WIDTH;
`else
    localparam int unsigned ADDR_Q_W = DEPTH_LOG2;
`endif

    logic [STAT_W-1:0]     state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_Q_W-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  mem_we_c;
    logic                  mem_re_c;
    logic                  addr_ok_c;
    logic                  req_wr_c;
    logic                  req_rd_c;

    assign req_wr_c = (mobo_ctrl == WORD_WIDTH'(CTRL_WRITE));
    assign req_rd_c = (mobo_ctrl == WORD_WIDTH'(CTRL_READ));

    // Address validity of the latched operand.
`ifdef MOBO_RESP_RANGE_CHECK_EN
    assign addr_ok_c = ((addr_q >> DEPTH_LOG2) == '0);
`else
    logic addr_hi_unused_c;
    assign addr_hi_unused_c = ^addr[WORD_WIDTH-1:DEPTH_LOG2];
    assign addr_ok_c        = 1'b1;
`endif

    // State, latency counter and operand latches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state, operand capture and memory strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        mem_we_c = 1'b0;
        mem_re_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_wr_c || req_rd_c) begin
                    is_wr_d = req_wr_c;
                    addr_d  = addr[ADDR_Q_W-1:0];
                    data_d  = mobodat_out;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (addr_ok_c) begin
                    mem_we_c = is_wr_q;
                    mem_re_c = !is_wr_q;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (mobo_ctrl == WORD_WIDTH'(CTRL_NONE)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mobo_stat = WORD_WIDTH'(state_q);

    mobo_mem_array #(
        .WORD_WIDTH(WORD_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we_c),
        .re   (mem_re_c),
        .addr (addr_q[DEPTH_LOG2-1:0]),
        .wdata(data_q),
        .rdata(mobodat_in)
    );

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Directed bench for mobo_mem_responder (LATENCY=2, DEPTH_LOG2=8).
module tb_mobo_mem_responder;

    localparam int unsigned W = 32;

    localparam logic [31:0] C_NONE  = 32'd0;
    localparam logic [31:0] C_WRITE = 32'd1;
    localparam logic [31:0] C_READ  = 32'd2;

    logic          clk;
    logic          rst;
    logic [W-1:0]  mobo_ctrl;
    logic [W-1:0]  addr;
    logic [W-1:0]  mobodat_out;
    logic [W-1:0]  mobo_stat;
    logic [W-1:0]  mobodat_in;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_stat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    mobo_mem_responder #(
        .WORD_WIDTH(32),
        .DEPTH_LOG2(8),
        .LATENCY(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mobo_ctrl  (mobo_ctrl),
        .addr       (addr),
        .mobodat_out(mobodat_out),
        .mobo_stat  (mobo_stat),
        .mobodat_in (mobodat_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, then CTRL_NONE; wait (bounded) for DONE/ERR.
    task automatic access(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] st, output logic [31:0] rd, output int lat);
        mobo_ctrl   = c;
        addr        = a;
        mobodat_out = d;
        tick();
        mobo_ctrl = C_NONE;
        lat = 1;
        while (mobo_stat == 32'd1 && lat < 20) begin
            tick();
            lat++;
        end
        st = mobo_stat;
        rd = mobodat_in;
        tick();
    endtask

    task automatic add(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] es, input logic [31:0] er);
        vec_t v;
        v.ctrl = c; v.addr = a; v.data = d; v.exp_stat = es; v.exp_rd = er;
        vecs.push_back(v);
    endtask

    logic [31:0] st;
    logic [31:0] rd;
    int          lat;

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        mobo_ctrl   = C_NONE;
        addr        = '0;
        mobodat_out = '0;

        // Write/read/latching table, one row per clock.
        add(C_WRITE, 32'd7, 32'h77, 1, 0);
        add(C_NONE,  32'd7, 32'h77, 1, 0);
        add(C_NONE,  32'd7, 32'h77, 2, 0);
        add(C_NONE,  32'd7, 32'h77, 0, 0);
        add(C_WRITE, 32'd3, 32'd5,  1, 0);
        add(C_NONE,  32'd7, 32'd9,  1, 0);
        add(C_NONE,  32'd7, 32'd9,  2, 0);
        add(C_NONE,  32'd7, 32'd9,  0, 0);
        add(C_READ,  32'd3, 32'd0,  1, 0);
        add(C_READ,  32'd3, 32'd0,  1, 0);
        add(C_READ,  32'd3, 32'd0,  2, 5);
        add(C_READ,  32'd3, 32'd0,  2, 5);
        add(C_NONE,  32'd3, 32'd0,  0, 5);
        add(C_WRITE, 32'd4, 32'hA,  1, 5);
        add(C_WRITE, 32'd7, 32'd9,  1, 5);
        add(C_NONE,  32'd7, 32'd9,  2, 5);
        add(C_NONE,  32'd7, 32'd9,  0, 5);
        add(C_READ,  32'd4, 32'd0,  1, 5);
        add(C_NONE,  32'd4, 32'd0,  1, 5);
        add(C_NONE,  32'd4, 32'd0,  2, 32'hA);
        add(C_NONE,  32'd4, 32'd0,  0, 32'hA);
        add(C_READ,  32'd7, 32'd0,  1, 32'hA);
        add(C_NONE,  32'd7, 32'd0,  1, 32'hA);
        add(C_NONE,  32'd7, 32'd0,  2, 32'h77);
        add(C_NONE,  32'd7, 32'd0,  0, 32'h77);

        // Reset for two cycles, then idle.
        tick();
        tick();
        check("reset_stat", mobo_stat, 32'd0);
        check("reset_rdata", mobodat_in, 32'd0);
        rst = 1'b1;
        tick();
        check("idle_stat", mobo_stat, 32'd0);

        foreach (vecs[i]) begin
            mobo_ctrl   = vecs[i].ctrl;
            addr        = vecs[i].addr;
            mobodat_out = vecs[i].data;
            tick();
            check($sformatf("vec%0d_stat", i), mobo_stat, vecs[i].exp_stat);
            check($sformatf("vec%0d_rdata", i), mobodat_in, vecs[i].exp_rd);
        end

        // Sticky DONE: hold CTRL_READ for 10 cycles after DONE.
        mobo_ctrl = C_READ;
        addr      = 32'd3;
        tick();
        tick();
        tick();
        check("sticky_first_done", mobo_stat, 32'd2);
        check("sticky_rdata", mobodat_in, 32'd5);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("sticky_hold%0d", k), mobo_stat, 32'd2);
        end
        mobo_ctrl = C_NONE;
        tick();
        check("sticky_release", mobo_stat, 32'd0);

        // Latency measured on a full access.
        access(C_WRITE, 32'd0, 32'h33, st, rd, lat);
        check("write0_stat", st, 32'd2);
        check("write0_latency", 32'(lat), 32'd3);
        access(C_READ, 32'd3, 32'd0, st, rd, lat);
        check("read3_rdata", rd, 32'd5);
        check("read3_latency", 32'(lat), 32'd3);

        // Out-of-range address.
        access(C_READ, 32'h100, 32'd0, st, rd, lat);
`ifdef MOBO_RESP_RANGE_CHECK_EN
        check("range_stat", st, 32'd3);
        check("range_rdata", rd, 32'd5);
`else
        check("range_stat", st, 32'd2);
        check("range_rdata", rd, 32'h33);
`endif
        check("range_back_idle", mobo_stat, 32'd0);

        // Reset during the first BUSY cycle of a write aborts it.
        access(C_WRITE, 32'd2, 32'h11, st, rd, lat);
        check("preload2_stat", st, 32'd2);
        mobo_ctrl   = C_WRITE;
        addr        = 32'd2;
        mobodat_out = 32'h55;
        tick();
        check("abort_busy", mobo_stat, 32'd1);
        rst       = 1'b0;
        mobo_ctrl = C_NONE;
        tick();
        check("abort_stat", mobo_stat, 32'd0);
        check("abort_rdata", mobodat_in, 32'd0);
        rst = 1'b1;
        tick();
        check("abort_idle", mobo_stat, 32'd0);
        access(C_READ, 32'd2, 32'd0, st, rd, lat);
        check("abort_read_stat", st, 32'd2);
        check("abort_read_rdata", rd, 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mobo_mem_responder.md
# mobo_mem_responder

Motherboard-side responder for the CPU memory handshake. It samples the CPU's `mobo_ctrl`, address and write-data outputs, and performs word reads and writes on an internal memory array after a programmable latency. It reports progress on `mobo_stat` and returns read data on `mobodat_in`. It sits on the mobo side of the CPU bus, completing the initiator/responder pair for the `CTRL_*`/`STAT_*` protocol.

## Interface
Parameters:
- `WORD_WIDTH`, 32: width of the ctrl, status, address and data words.
- `DEPTH_LOG2`, 8: log2 of the number of memory words.
- `LATENCY`, 2: BUSY cycles per access; legal range is ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `mobo_ctrl`  in  WORD_WIDTH  request code: `CTRL_NONE`=0, `CTRL_WRITE`=1, `CTRL_READ`=2.
- `addr`  in  WORD_WIDTH  word address (word-indexed, not byte-indexed).
- `mobodat_out`  in  WORD_WIDTH  write data from the CPU.
- `mobo_stat`  out  WORD_WIDTH  status: `STAT_IDLE`=0, `STAT_BUSY`=1, `STAT_DONE`=2, `STAT_ERR`=3.
- `mobodat_in`  out  WORD_WIDTH  read data to the CPU.

## Operation
- FSM states are S_IDLE, S_BUSY, S_DONE and S_ERR. `mobo_stat` is registered and equals the encoding of the current state.
- **S_IDLE**
  - On `CTRL_WRITE` or `CTRL_READ`, latch op, `addr` and `mobodat_out`, load `cnt`=LATENCY-1, and go to S_BUSY.
  - `CTRL_NONE` and any other code: remain in S_IDLE.
- **S_BUSY**
  - Inputs are ignored; the latched operands are used.
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`=0 and the address is valid: perform the access and go to S_DONE.
    - Write: `mem[addr]` ← data.
    - Read: the `mobodat_in` register ← `mem[addr]`.
  - If `cnt`=0 and the address is invalid: go to S_ERR with no access.
- **S_DONE / S_ERR**
  - Hold until `mobo_ctrl`=`CTRL_NONE`, then go to S_IDLE.
  - A request code still present keeps the state; there is no re-trigger.
- `mobodat_in` holds its value until the next successful read completes. Writes, errors and `CTRL_NONE` do not change it.
- Back-to-back requests require one S_IDLE cycle with `CTRL_NONE` between them.

## Timing
- Reset:
  - `mobo_stat`=0 (`STAT_IDLE`), `mobodat_in`=0, state=S_IDLE, `cnt`=0.
  - Memory contents are not cleared; they are undefined until written.
- A request sampled at edge E0 gives the following `mobo_stat` sequence:
  - `STAT_BUSY` after edges E0 … E0+LATENCY-1.
  - `STAT_DONE`/`STAT_ERR` after edge E0+LATENCY.
  - Total latency: LATENCY+1 cycles from the request being presented to DONE being visible.
- Read data is valid in the same cycle `STAT_DONE` first appears.
- Return to `STAT_IDLE` occurs one edge after `CTRL_NONE` is sampled in S_DONE/S_ERR.
- Reset asserted mid-operation: the access is aborted and no write is committed unless the commit edge has already passed. The state returns to S_IDLE on that edge.
- Reset has priority over every transition.

## Configuration
- `MOBO_RESP_RANGE_CHECK_EN`
  - Defined: an address ≥ 2^DEPTH_LOG2 (any nonzero upper bit) terminates in S_ERR. In that case no memory write occurs and `mobodat_in` is unchanged.
  - Undefined: only the low DEPTH_LOG2 address bits are used, so addresses wrap modulo depth and S_ERR is unreachable.

## Structure
- `CTRL_*` and `STAT_*` encodings live in the shared mobo states include, common with the CPU side.
- Responder FSM state encodings stay local to this block.
- One sub-module: `mobo_mem_array` (parameters WORD_WIDTH, DEPTH_LOG2; synchronous write enable; registered read). The responder FSM, operand latches and latency counter stay in the top module.

## Test plan
- Reset then idle: hold `rst`=0 for 2 cycles, release → `mobo_stat`=0 and `mobodat_in`=0; `mobo_stat` stays 0 with `CTRL_NONE`.
- Write then read: write `addr`=3, data=5, then read `addr`=3 → BUSY for exactly 2 cycles, DONE on the 3rd cycle after each request, `mobodat_in`=5 with DONE.
- Sticky DONE: hold `CTRL_READ` for 10 cycles after DONE → `mobo_stat` stays 2 with no second access; drop to `CTRL_NONE` → `mobo_stat`=0 one edge later.
- Operand latching: change `addr`/`mobodat_out` to 7/9 during BUSY of a write to 4/0xA → `mem[4]`=0xA, `mem[7]` untouched.
- Range check: read `addr`=0x100 (DEPTH_LOG2=8).
  - With the macro defined: `mobo_stat`=3, `mobodat_in` unchanged.
  - Without it: returns `mem[0]`.
- Reset mid-access: assert `rst`=0 during the first BUSY cycle of a write to `addr`=2, data=0x55 → `mobo_stat`=0 next cycle; a subsequent read of `addr`=2 does not return 0x55 (preload 0x11).
